// File: rtl/fpu_bus_port.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_bus_port
//  Description : 8-bit CPU-bus register front end for a combinational FPU.
//                Holds operands, issues the command, waits a settle count and
//                captures the FPU result for byte-wise read-back.
//  Revision    : 1.0  initial release
// ============================================================================

package pa_fpu;
    typedef enum logic [1:0] {
        op_add = 2'd0,
        op_sub = 2'd1,
        op_mul = 2'd2,
        op_div = 2'd3
    } e_fpu_op;
endpackage

module fpu_bus_port #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           cs,
    input  logic           wr,
    input  logic           rd,
    input  logic [3:0]     addr,
    input  logic [7:0]     data_in,
    output logic [7:0]     data_out,
    output logic           busy,
    output logic           done,
    output logic [31:0]    fpu_a,
    output logic [31:0]    fpu_b,
    output pa_fpu::e_fpu_op fpu_op,
    input  logic [31:0]    fpu_result
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_addr_cmd    = 4'h8;
    localparam logic [3:0] c_addr_status = 4'h9;

    state_t      r_state;
    logic [7:0]  r_count;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic        r_err;

    logic        w_wr;
    logic        w_rd;
    logic        w_settling;
    logic        w_reg_wr;
    logic        w_drop;
    logic        w_accept;
    logic        w_status_rd;
    logic [4:0]  w_bit_sel;
    logic [7:0]  w_rd_byte;

    assign fpu_a = r_a;
    assign fpu_b = r_b;

    assign w_wr        = cs & wr;
    assign w_rd        = cs & rd & ~wr;
    assign w_settling  = (r_state == ST_SETTLE);
    assign w_reg_wr    = w_wr & (addr <= c_addr_cmd);
    assign w_drop      = w_reg_wr & w_settling;
    assign w_accept    = w_wr & (addr == c_addr_cmd) & ~w_settling;
    assign w_status_rd = w_rd & (addr == c_addr_status);
    assign w_bit_sel   = {addr[1:0], 3'b000};

    always_comb begin
        w_rd_byte = 8'h00;
        case (addr[3:2])
            2'b00:   w_rd_byte = r_a[w_bit_sel +: 8];
            2'b01:   w_rd_byte = r_b[w_bit_sel +: 8];
            2'b10:   if (addr == c_addr_status) w_rd_byte = {5'b0, r_err, done, busy};
            default: w_rd_byte = r_result[w_bit_sel +: 8];
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= 8'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_result <= 32'd0;
            r_err    <= 1'b0;
            fpu_op   <= pa_fpu::op_add;
            data_out <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (w_rd) begin
                data_out <= w_rd_byte;
            end

            // A drop and a STATUS read cannot coincide (read needs !wr), so set wins trivially.
            r_err <= w_drop | (r_err & ~w_status_rd);

            if (w_reg_wr && !w_settling && !addr[3]) begin
                if (!addr[2]) begin
                    r_a[w_bit_sel +: 8] <= data_in;
                end else begin
                    r_b[w_bit_sel +: 8] <= data_in;
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        fpu_op  <= pa_fpu::e_fpu_op'(data_in[1:0]);
                        r_count <= c_settle_load;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_count == 8'd0) begin
                        r_result <= fpu_result;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_bus_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_bus_port
//  Description : Scoreboard bench for fpu_bus_port with a table-driven FPU stand-in.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_fpu_bus_port;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            cs = 1'b0;
    logic            wr = 1'b0;
    logic            rd = 1'b0;
    logic [3:0]      addr = 4'h0;
    logic [7:0]      data_in = 8'h00;
    logic [7:0]      data_out;
    logic            busy;
    logic            done;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    pa_fpu::e_fpu_op fpu_op;
    logic [31:0]     fpu_result;

    logic [7:0]      data_out1;
    logic            busy1;
    logic            done1;
    logic [31:0]     fpu_a1;
    logic [31:0]     fpu_b1;
    pa_fpu::e_fpu_op fpu_op1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_rd[$];
    string      exp_rd_name[$];
    int         exp_done[$];
    logic       rd_seen = 1'b0;
    logic       done_prev = 1'b0;
    int         busy_cnt = 0;

    fpu_bus_port #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .arst_n(arst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
        .data_in(data_in), .data_out(data_out), .busy(busy), .done(done),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_result(fpu_result)
    );

    fpu_bus_port #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .arst_n(arst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
        .data_in(data_in), .data_out(data_out1), .busy(busy1), .done(done1),
        .fpu_a(fpu_a1), .fpu_b(fpu_b1), .fpu_op(fpu_op1), .fpu_result(fpu_result)
    );

    always #5 clk = ~clk;

    // Stand-in FPU: known IEEE results for the directed operands, a simple mix otherwise.
    function automatic logic [31:0] fpu_model(logic [31:0] a, logic [31:0] b, logic [1:0] op);
        if (a == 32'h3f800000 && b == 32'h3f8ccccd && op == 2'd0) return 32'h40066666;
        if (a == 32'h3f800000 && b == 32'h3f8ccccd && op == 2'd1) return 32'hbdcccccd;
        if (a == 32'h7f800000 && b == 32'h7f800000 && op == 2'd0) return 32'h7f800000;
        if (a == 32'h7f800000 && b == 32'h7f800000 && op == 2'd1) return 32'h7fc00000;
        return a ^ b ^ {30'd0, op};
    endfunction

    assign fpu_result = fpu_model(fpu_a, fpu_b, 2'(fpu_op));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= arst_n && cs && rd && !wr;
    end

    // Monitor: pops expectations whenever the DUT presents read data or raises done.
    always @(negedge clk) begin
        if (!arst_n) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (rd_seen) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_read", 32'(data_out), 32'hffffffff);
                end else begin
                    chk(exp_rd_name.pop_front(), 32'(data_out), 32'(exp_rd.pop_front()));
                end
            end
            if (done && !done_prev) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'(cyc), 32'hffffffff);
                end else begin
                    chk("done_latency", 32'(cyc), 32'(exp_done.pop_front()));
                    chk("busy_cycles", 32'(busy_cnt), 32'd4);
                end
                busy_cnt = 0;
            end
            done_prev = done;
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; data_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        exp_rd.push_back(exp);
        exp_rd_name.push_back(name);
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] base, input logic [31:0] v);
        for (int i = 0; i < 4; i++) bus_write(base + 4'(i), v[8*i +: 8]);
    endtask

    task automatic read_result(input logic [31:0] v, input string name);
        for (int i = 0; i < 4; i++) bus_read(4'hC + 4'(i), v[8*i +: 8], name);
    endtask

    task automatic issue_cmd(input logic [7:0] cmd);
        bus_write(4'h8, cmd);
        exp_done.push_back(cyc + 4);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_fpu_b", fpu_b, 32'd0);
        chk("rst_fpu_op", 32'(fpu_op), 32'd0);
        chk("rst_dut1", {fpu_b1[23:0], data_out1}, 32'd0);
        arst_n = 1'b1;
        bus_read(4'h9, 8'h00, "rst_status");
        bus_read(4'hC, 8'h00, "rst_result0");

        // 1.0 + 1.1
        write_word(4'h0, 32'h3f800000);
        write_word(4'h4, 32'h3f8ccccd);
        chk("fpu_a_reflect", fpu_a, 32'h3f800000);
        chk("fpu_b_reflect", fpu_b, 32'h3f8ccccd);
        issue_cmd(8'h00);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("s1_busy_after_accept", {30'd0, busy1, done1}, 32'd2);
        @(posedge clk);
        #1;
        chk("s1_done_one_clk", {30'd0, busy1, done1}, 32'd1);
        chk("s1_fpu_a", fpu_a1, 32'h3f800000);
        wait_done("add_done");
        read_result(32'h40066666, "add_result");
        bus_read(4'h9, 8'h02, "add_status");

        // Subtract, CMD upper bits ignored
        issue_cmd(8'hFD);
        chk("op_sub_latched", 32'(fpu_op), 32'd1);
        wait_done("sub_done");
        read_result(32'hbdcccccd, "sub_result");
        bus_read(4'h9, 8'h02, "sub_status");

        // inf - inf, then inf + inf issued from DONE
        write_word(4'h0, 32'h7f800000);
        write_word(4'h4, 32'h7f800000);
        issue_cmd(8'h01);
        wait_done("nan_done");
        read_result(32'h7fc00000, "nan_result");
        issue_cmd(8'h00);
        chk("done_drops", 32'(done), 32'd0);
        wait_done("inf_done");
        read_result(32'h7f800000, "inf_result");

        // Write during SETTLE is dropped and flags err
        issue_cmd(8'h00);
        bus_write(4'h0, 8'h55);
        chk("a_unchanged", fpu_a, 32'h7f800000);
        wait_done("drop_done");
        read_result(32'h7f800000, "drop_result");
        bus_read(4'h9, 8'h06, "status_err");
        bus_read(4'h9, 8'h02, "status_err_cleared");

        // Reset two clocks into SETTLE
        issue_cmd(8'h02);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b0;
        exp_done.delete();
        repeat (2) @(negedge clk);
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        chk("abort_data_out", 32'(data_out), 32'd0);
        chk("abort_fpu_a", fpu_a, 32'd0);
        chk("abort_fpu_op", 32'(fpu_op), 32'd0);
        arst_n = 1'b1;
        bus_read(4'h9, 8'h00, "abort_status");
        bus_read(4'hC, 8'h00, "abort_result0");
        write_word(4'h0, 32'h3f800000);
        write_word(4'h4, 32'h3f8ccccd);
        issue_cmd(8'h00);
        wait_done("post_abort_done");
        read_result(32'h40066666, "post_abort_result");

        // cs low: strobes on every address must do nothing
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cs = 1'b0; addr = 4'(i); data_in = 8'hFF;
            wr = (i % 3) != 1; rd = (i % 2) == 0;
        end
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        chk("cs0_data_out", 32'(data_out), 32'h40);
        chk("cs0_fpu_a", fpu_a, 32'h3f800000);
        chk("cs0_fpu_b", fpu_b, 32'h3f8ccccd);
        chk("cs0_done", {30'd0, busy, done}, 32'd1);
        bus_read(4'hB, 8'h00, "unmapped_b");

        // rd and wr together: write wins, data_out holds
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 4'h0; data_in = 8'h11;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        chk("rdwr_write", fpu_a, 32'h3f800011);
        chk("rdwr_hold", 32'(data_out), 32'h00);
        bus_read(4'h9, 8'h02, "final_status");

        repeat (3) @(negedge clk);
        chk("reads_drained", 32'(exp_rd.size()), 32'd0);
        chk("dones_drained", 32'(exp_done.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
